// File: rtl/relu_maxpool2x2_if.sv
// Sample stream bundle between an upstream conv filter, the ReLU/max-pool stage
// and the next layer's input FIFO. There is no backpressure on either side.
interface relu_maxpool2x2_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;

  modport master (
    output valid_in,
    output data_in,
    input  valid_out,
    input  data_out,
    input  frame_done
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output valid_out,
    output data_out,
    output frame_done
  );
endinterface

// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling on a raster float stream. Uses a
// half-row line buffer; odd trailing columns/rows are dropped (floor pooling).
module relu_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic            clk,
  input  logic            rst,
  relu_maxpool2x2_if.slave bus
);

  localparam int COL_W      = (WIDTH  > 4) ? $clog2(WIDTH)  : 2;
  localparam int ROW_W      = (HEIGHT > 4) ? $clog2(HEIGHT) : 2;
  localparam int IDX_W      = COL_W - 1;
  localparam int LBUF_DEPTH = 1 << IDX_W;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_POOL_LAST = COL_W'(2 * (WIDTH / 2) - 1);
  localparam logic [ROW_W-1:0] ROW_POOL_LAST = ROW_W'(2 * (HEIGHT / 2) - 1);

  // Sign bit set (including -0.0) clamps to +0.0.
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  // Operands are non-negative after ReLU, so raw-bit unsigned order equals float order.
  function automatic logic [DATA_WIDTH-1:0] max_u(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] hreg;
  logic [DATA_WIDTH-1:0] lbuf [LBUF_DEPTH];

  logic [DATA_WIDTH-1:0] relu_p0;
  logic [DATA_WIDTH-1:0] h_p0;
  logic [DATA_WIDTH-1:0] lbuf_rd_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic                  col_pair_p0;
  logic                  row_pair_p0;
  logic                  hreg_wr_p0;
  logic                  lbuf_wr_p0;
  logic                  pool_p0;
  logic                  last_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  done_p1;

  // ---- stage p0: accepted sample, horizontal pair and line-buffer lookup ----
  always_comb begin
    relu_p0     = relu(bus.data_in);
    h_p0        = max_u(hreg, relu_p0);
    idx_p0      = col[COL_W-1:1];
    lbuf_rd_p0  = lbuf[idx_p0];
    col_pair_p0 = (WIDTH % 2 == 0) || (col != COL_LAST);
    row_pair_p0 = (HEIGHT % 2 == 0) || (row != ROW_LAST);
    hreg_wr_p0  = bus.valid_in && !col[0] && col_pair_p0;
    lbuf_wr_p0  = bus.valid_in && !row[0] && col[0] && row_pair_p0;
    pool_p0     = bus.valid_in && row[0] && col[0];
    last_p0     = pool_p0 && (row == ROW_POOL_LAST) && (col == COL_POOL_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hreg <= '0;
    end else if (hreg_wr_p0) begin
      hreg <= relu_p0;
    end
  end

  // Every entry is rewritten on an even row before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (lbuf_wr_p0) begin
      lbuf[idx_p0] <= h_p0;
    end
  end

  // ---- stage p1: registered pooled output ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= pool_p0;
      done_p1 <= last_p0;
      if (pool_p0) begin
        data_p1 <= max_u(lbuf_rd_p0, h_p0);
      end
    end
  end

  assign bus.valid_out  = vld_p1;
  assign bus.data_out   = data_p1;
  assign bus.frame_done = done_p1;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2: a 4x4 instance for the main scenarios and
// a 5x5 instance for floor pooling with back-to-back frames.
module tb_relu_maxpool2x2;

  typedef struct {
    logic [31:0] d;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   fin_req = 1'b0;
  bit   fin_ack = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  int   ra = 0;
  int   rb = 0;

  logic [31:0] frm [0:4][0:4];

  relu_maxpool2x2_if #(.DATA_WIDTH(32)) ba ();
  relu_maxpool2x2_if #(.DATA_WIDTH(32)) bb ();

  relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] relu_m(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] max4(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    logic [31:0] m;
    m = relu_m(a);
    if (relu_m(b) > m) m = relu_m(b);
    if (relu_m(c) > m) m = relu_m(c);
    if (relu_m(d) > m) m = relu_m(d);
    return m;
  endfunction

  task automatic drive(input int d, input logic v, input logic [31:0] x);
    if (d == 0) begin
      ba.valid_in = v;
      ba.data_in  = x;
    end else begin
      bb.valid_in = v;
      bb.data_in  = x;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive(0, 1'b0, $urandom);
      drive(1, 1'b0, $urandom);
    end
  endtask

  task automatic set_row(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e);
    frm[r][0] = a; frm[r][1] = b; frm[r][2] = c; frm[r][3] = e;
  endtask

  // Feeds frm in raster order; each completing sample of a full 2x2 window
  // queues the window maximum, due one cycle after the sample is presented.
  task automatic drive_frame(input int d, input int w, input int h,
                             input int gap, input int nmax);
    int   n;
    exp_t e;
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n < nmax) begin
          @(posedge clk); #1;
          drive(d, 1'b1, frm[r][c]);
          if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2))) begin
            e.d    = max4(frm[r-1][c-1], frm[r-1][c], frm[r][c-1], frm[r][c]);
            e.done = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
            e.cyc  = cyc + 1;
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
          end
          n++;
          for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            drive(d, 1'b0, $urandom);
          end
        end
      end
    end
  endtask

  task automatic load_s2();
    set_row(0, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000);
    set_row(1, 32'h3F000000, 32'h3F000000, 32'h40400000, 32'h3F800000);
    set_row(2, 32'h40800000, 32'h3E800000, 32'hBF800000, 32'h3FC00000);
    set_row(3, 32'h00000000, 32'hC0000000, 32'h40200000, 32'h3F400000);
  endtask

  task automatic load_rand5();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        frm[r][c] = (r == 4 || c == 4) ? 32'h7F000000 : $urandom;
  endtask

  // Output monitor and scoreboard comparisons, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks += 2;
        assert (ba.valid_out === 1'b0 && ba.data_out === 32'h0 && ba.frame_done === 1'b0)
          else begin errors++; $error("FAIL rst_a got v=%b d=%h f=%b expected v=0 d=00000000 f=0", ba.valid_out, ba.data_out, ba.frame_done); end
        assert (bb.valid_out === 1'b0 && bb.data_out === 32'h0 && bb.frame_done === 1'b0)
          else begin errors++; $error("FAIL rst_b got v=%b d=%h f=%b expected v=0 d=00000000 f=0", bb.valid_out, bb.data_out, bb.frame_done); end
      end else begin
        if (ba.valid_out === 1'b1) begin
          checks++;
          assert (ra < qa.size())
            else begin errors++; $error("FAIL extra_a got valid_out=1 at cycle %0d expected no output", cyc); end
          if (ra < qa.size()) begin
            e = qa[ra];
            ra++;
            checks += 3;
            assert (ba.data_out === e.d)
              else begin errors++; $error("FAIL data_a#%0d got %h expected %h", ra, ba.data_out, e.d); end
            assert (ba.frame_done === e.done)
              else begin errors++; $error("FAIL done_a#%0d got %b expected %b", ra, ba.frame_done, e.done); end
            assert (cyc === e.cyc)
              else begin errors++; $error("FAIL lat_a#%0d got cycle %0d expected cycle %0d", ra, cyc, e.cyc); end
          end
        end else begin
          checks++;
          assert (ba.frame_done === 1'b0)
            else begin errors++; $error("FAIL idle_done_a got %b expected 0", ba.frame_done); end
        end
        if (bb.valid_out === 1'b1) begin
          checks++;
          assert (rb < qb.size())
            else begin errors++; $error("FAIL extra_b got valid_out=1 at cycle %0d expected no output", cyc); end
          if (rb < qb.size()) begin
            e = qb[rb];
            rb++;
            checks += 3;
            assert (bb.data_out === e.d)
              else begin errors++; $error("FAIL data_b#%0d got %h expected %h", rb, bb.data_out, e.d); end
            assert (bb.frame_done === e.done)
              else begin errors++; $error("FAIL done_b#%0d got %b expected %b", rb, bb.frame_done, e.done); end
            assert (cyc === e.cyc)
              else begin errors++; $error("FAIL lat_b#%0d got cycle %0d expected cycle %0d", rb, cyc, e.cyc); end
          end
        end else begin
          checks++;
          assert (bb.frame_done === 1'b0)
            else begin errors++; $error("FAIL idle_done_b got %b expected 0", bb.frame_done); end
        end
      end
      if (fin_req && !fin_ack) begin
        checks += 2;
        assert (ra == qa.size())
          else begin errors++; $error("FAIL count_a got %0d outputs expected %0d", ra, qa.size()); end
        assert (rb == qb.size())
          else begin errors++; $error("FAIL count_b got %0d outputs expected %0d", rb, qb.size()); end
        fin_ack = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        frm[r][c] = 32'h0;

    // Reset held with activity on the inputs
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(0, i[0], $urandom);
      drive(1, ~i[0], $urandom);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    idle(2);

    // All ones
    for (int r = 0; r < 4; r++)
      set_row(r, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    drive_frame(0, 4, 4, 0, 16);
    idle(3);

    // Max selection
    load_s2();
    drive_frame(0, 4, 4, 0, 16);
    idle(3);

    // ReLU, negative zero, denormal and extreme values
    set_row(0, 32'hC0400000, 32'h80000000, 32'hC0400000, 32'h3F000000);
    set_row(1, 32'h80000000, 32'hC0400000, 32'hBF800000, 32'hC0000000);
    set_row(2, 32'h80000000, 32'h80000000, 32'h7F7FFFFF, 32'h00000001);
    set_row(3, 32'hBF800000, 32'h00000001, 32'hFF800000, 32'h3F800000);
    drive_frame(0, 4, 4, 0, 16);
    idle(3);

    // Bubbles of three cycles between samples
    load_s2();
    drive_frame(0, 4, 4, 3, 16);
    idle(3);

    // Reset in the middle of a frame, then a clean frame
    drive_frame(0, 4, 4, 0, 6);
    idle(2);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    set_row(0, 32'h3E800000, 32'h3F400000, 32'h40A00000, 32'h3F800000);
    set_row(1, 32'h3F000000, 32'hBF800000, 32'h40000000, 32'h40C00000);
    set_row(2, 32'hC1000000, 32'h80000000, 32'h3F800000, 32'h3F800001);
    set_row(3, 32'h80000000, 32'hC0000000, 32'h3F7FFFFF, 32'h3F000000);
    drive_frame(0, 4, 4, 0, 16);
    idle(3);

    // 5x5 floor pooling, two frames back to back
    load_rand5();
    drive_frame(1, 5, 5, 0, 25);
    load_rand5();
    drive_frame(1, 5, 5, 0, 25);
    idle(5);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
